alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Sequencing stage directly upstream of the 16-bit ALU.
- Accepts one operation per valid/ready handshake and registers the operands and opcode onto the ALU inputs.
- Holds them for a fixed settle interval, then captures the ALU result and recomputes the flag locally.
- Presents {result, z, err} on a valid/ready response port to the writeback/branch logic.
- The ALU's own z output is not used; the flag is derived from the captured result.

Parameters:
- WIDTH, 16, data width of operands and result
- SETTLE_FAST, 1, EXEC cycles for ops 1, 2, 6 (add, sub, xor)
- SETTLE_SLOW, 3, EXEC cycles for ops 3, 4, 5 (mul, div, mod)
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  stage can accept a request
- req_op  in  3  ALU opcode: 1 add, 2 sub, 3 mul, 4 div, 5 mod, 6 xor
- req_a  in  WIDTH  operand driven to ALU in1
- req_b  in  WIDTH  operand driven to ALU in2
- alu_in1  out  WIDTH  registered operand to ALU
- alu_in2  out  WIDTH  registered operand to ALU
- alu_op  out  3  registered opcode to ALU
- alu_out  in  WIDTH  combinational ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  captured result
- rsp_z  out  1  flag: rsp_data[WIDTH-1] OR (rsp_data == 0)
- rsp_err  out  1  invalid opcode (0, 7) or div/mod by zero
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed responses, wraps at 2^CNT_W

Behaviour:
- Reset (async, reset_n=0) forces state IDLE.
  - Zeroes alu_in1, alu_in2, alu_op, rsp_data, rsp_z, rsp_err, rsp_valid and op_count.
  - req_ready=1 and busy=0 immediately.
  - Reset asserted mid-operation abandons the operation; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch req_a→alu_in1, req_b→alu_in2, req_op→alu_op.
  - Load the settle counter with SETTLE_FAST or SETTLE_SLOW per opcode.
  - Go to EXEC.
  - Exception: invalid opcode (0 or 7), or op 4/5 with req_a==0, bypasses EXEC and goes straight to RESP with rsp_data=0, rsp_z=1, rsp_err=1.
  - In the bypass case alu_op is set to 0 so the ALU is not exercised.
- EXEC:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 1, capture alu_out→rsp_data, compute rsp_z from the captured value, set rsp_err=0, and go to RESP.
  - Latency from accept to rsp_valid is 1+SETTLE cycles: 2 for fast ops, 4 for slow ops.
- RESP:
  - rsp_valid=1; rsp_data, rsp_z and rsp_err are stable until the handshake.
  - On rsp_ready, the next state is IDLE and op_count increments by 1, including error responses.
- No new request is accepted in the cycle the response handshakes. req_ready rises the following cycle.
  - Peak throughput is therefore one op per 3 cycles (fast) or 5 cycles (slow).
- ALU inputs hold their last values outside EXEC; they are not cleared after completion.
- Arithmetic is unsigned WIDTH-bit with truncation; the stage performs no arithmetic except the z compare and the divisor-zero check.
- op_count wraps from all-ones to 0 with no saturation.
- req_* changing while req_ready=0 has no effect.

Decomposition:
- Shared package (alu_pkg):
  - opcode constants OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4, OP_MOD=5, OP_XOR=6
  - state enum {IDLE, EXEC, RESP}
  - function is_slow(op)
  - function is_valid_op(op)
- No sub-module needed; the ALU stays an external instance connected at the core level.
- The bench instantiates this stage together with the existing ALU.

Test Plan:
- Reset, then send op=1, a=5, b=7 with rsp_ready=1. Required: req_ready low 2 cycles after accept; rsp_valid on cycle 2 with rsp_data=12, rsp_z=0, rsp_err=0; op_count=1.
- op=2, a=9, b=4. Required: rsp_data=0xFFFB, rsp_z=1 (sign bit). Then op=6, a=0x00FF, b=0x00FF: rsp_data=0, rsp_z=1.
- op=4, a=3, b=20. Required: rsp_valid exactly 4 cycles after accept, rsp_data=6. Then op=5, a=0, b=20: immediate RESP with rsp_data=0, rsp_z=1, rsp_err=1, and alu_op=0.
- op=7 request. Required: rsp_err=1. Then hold rsp_ready=0 for 10 cycles: rsp_valid, rsp_data, rsp_z and rsp_err stay stable; req_ready=0 throughout; op_count unchanged until the handshake.
- Deassert reset_n during EXEC of a mul. Required: all outputs zero asynchronously, and no response appears after reset release.
- Preload op_count=0xFFFF via 65535 fast ops, then complete one more. Required: op_count wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encoding, issue-stage states and opcode classification helpers
// shared by the ALU issue stage and its surroundings.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_slow(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

endpackage

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 16-bit ALU: registers one operation onto the ALU
// inputs, waits a per-opcode settle interval, then returns {result, z, err}.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SETTLE_FAST = 1,
    parameter int SETTLE_SLOW = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t     state;
    logic [7:0] settle_cnt;
    logic       bypass;

    // Div/mod divisor is in1 (req_a); a zero divisor is answered without the ALU.
    assign bypass = !is_valid_op(req_op) ||
                    (((req_op == OP_DIV) || (req_op == OP_MOD)) && (req_a == '0));

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_z      <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_in1 <= req_a;
                        alu_in2 <= req_b;
                        if (bypass) begin
                            alu_op    <= '0;
                            rsp_data  <= '0;
                            rsp_z     <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_op     <= req_op;
                            settle_cnt <= is_slow(req_op) ? 8'(SETTLE_SLOW) : 8'(SETTLE_FAST);
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // <=1 rather than ==1 so a zero settle setting cannot wedge the stage
                    if (settle_cnt <= 8'd1) begin
                        rsp_data  <= alu_out;
                        rsp_z     <= alu_out[WIDTH-1] | (alu_out == '0);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU; a narrow-counter
// copy of the stage shares the stimulus so counter wrap is reached quickly.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid, rsp_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b;

    logic         req_ready, rsp_valid, rsp_z, rsp_err, busy;
    logic [W-1:0] alu_in1, alu_in2, alu_out, rsp_data;
    logic [2:0]   alu_op;
    logic [15:0]  op_count;

    logic         req_ready_s, rsp_valid_s, rsp_z_s, rsp_err_s, busy_s;
    logic [W-1:0] alu_in1_s, alu_in2_s, alu_out_s, rsp_data_s;
    logic [2:0]   alu_op_s;
    logic [3:0]   op_count_s;

    typedef struct packed {
        logic [W-1:0] data;
        logic         z;
        logic         err;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    // Existing ALU behaviour: sub/div/mod are in2 (op) in1.
    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return b - a;
            3'd3:    return a * b;
            3'd4:    return (a == '0) ? '0 : b / a;
            3'd5:    return (a == '0) ? '0 : b % a;
            3'd6:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_out   = alu_f(alu_op, alu_in1, alu_in2);
    assign alu_out_s = alu_f(alu_op_s, alu_in1_s, alu_in2_s);

    alu_issue_stage #(.WIDTH(W), .SETTLE_FAST(1), .SETTLE_SLOW(3), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_z(rsp_z),
        .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    alu_issue_stage #(.WIDTH(W), .SETTLE_FAST(1), .SETTLE_SLOW(3), .CNT_W(4)) u_dut_s (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready_s), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_in1(alu_in1_s), .alu_in2(alu_in2_s), .alu_op(alu_op_s), .alu_out(alu_out_s),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_data(rsp_data_s), .rsp_z(rsp_z_s),
        .rsp_err(rsp_err_s), .busy(busy_s), .op_count(op_count_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_z",    32'(rsp_z),    32'(e.z));
                chk("rsp_err",  32'(rsp_err),  32'(e.err));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic ez, input logic ee,
                        input logic [2:0] eop, input int elat, input int hold);
        int   lat;
        bit   got;
        rsp_t e;
        rsp_ready = (hold == 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        e.data = ed; e.z = ez; e.err = ee;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0; req_op = 3'd7; req_a = 16'hDEAD; req_b = 16'hBEEF;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = rsp_valid;
            if (req_ready !== 1'b0) chk("req_ready_low", 32'(req_ready), 32'd0);
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("alu_op", 32'(alu_op), 32'(eop));
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(ed));
            chk("hold_z_err", {30'd0, rsp_z, rsp_err}, {30'd0, ez, ee});
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_count", 32'(op_count), 32'(exp_cnt));
            @(negedge clk);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("op_count", 32'(op_count), 32'(exp_cnt & 16'hFFFF));
        chk("op_count_s", 32'(op_count_s), 32'(exp_cnt & 4'hF));
        chk("post_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready_busy", {30'd0, req_ready, busy}, 32'b10);
        chk("rst_rsp", {rsp_valid, rsp_z, rsp_err, 13'd0, rsp_data}, 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        reset_n = 1'b1;

        send(OP_ADD, 16'd5,     16'd7,     16'd12,     1'b0, 1'b0, OP_ADD, 2, 0);
        send(OP_SUB, 16'd9,     16'd4,     16'hFFFB,   1'b1, 1'b0, OP_SUB, 2, 0);
        send(OP_XOR, 16'h00FF,  16'h00FF,  16'h0000,   1'b1, 1'b0, OP_XOR, 2, 0);
        send(OP_DIV, 16'd3,     16'd20,    16'd6,      1'b0, 1'b0, OP_DIV, 4, 0);
        send(OP_MOD, 16'd0,     16'd20,    16'd0,      1'b1, 1'b1, 3'd0,   1, 0);
        send(OP_MOD, 16'd7,     16'd20,    16'd6,      1'b0, 1'b0, OP_MOD, 4, 0);
        send(OP_MUL, 16'h0100,  16'h0100,  16'h0000,   1'b1, 1'b0, OP_MUL, 4, 0);
        send(OP_DIV, 16'd0,     16'd5,     16'd0,      1'b1, 1'b1, 3'd0,   1, 0);
        send(3'd7,   16'd1,     16'd2,     16'd0,      1'b1, 1'b1, 3'd0,   1, 10);
        send(3'd0,   16'd1,     16'd2,     16'd0,      1'b1, 1'b1, 3'd0,   1, 0);

        // Reset during EXEC of a mul: everything clears and no response follows.
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MUL; req_a = 16'd3; req_b = 16'd5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_ready_busy", {30'd0, req_ready, busy}, 32'b10);
        chk("arst_rsp", {rsp_valid, rsp_z, rsp_err, 13'd0, rsp_data}, 32'd0);
        chk("arst_alu", {alu_op, alu_in1[12:0], alu_in2}, 32'd0);
        chk("arst_count", 32'(op_count), 32'd0);
        chk("arst_count_s", 32'(op_count_s), 32'd0);
        exp_cnt = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("no_rsp_after_reset", 32'(seen), 32'd0);

        // 16 fast ops: the 4-bit counter copy reaches all-ones and wraps to 0.
        for (int i = 0; i < 16; i++)
            send(OP_ADD, 16'(i), 16'd1, 16'(i + 1), 1'b0, 1'b0, OP_ADD, 2, 0);
        chk("wrap_s", 32'(op_count_s), 32'd0);
        chk("count_16", 32'(op_count), 32'd16);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
